// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: byte handshake between producer and UART transmitter.
// master = producer, slave = transmitter.
interface uart_transmitter_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter: tick-paced 8N1/8N2 serial transmitter, one-byte holding buffer.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_transmitter #(
  parameter int SAMPLES   = 16,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  uart_transmitter_if.slave bus,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(STOP_BITS * SAMPLES);
  localparam logic [CW-1:0] BIT_END  = CW'(SAMPLES - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * SAMPLES - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    hold;
  logic          hold_full;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  logic accept;
  logic bit_end;
  logic stop_end;

  // ready reflects only the registered buffer flag, so accept
  // and unload are mutually exclusive
  assign bus.tx_ready = ~hold_full;
  assign accept       = bus.tx_valid & ~hold_full;
  assign bit_end      = tick & (cnt == BIT_END);
  assign stop_end     = tick & (cnt == STOP_END);

  // frame sequencer, holding buffer and registered line outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (hold_full) begin
            state     <= START;
            shreg     <= hold;
            hold_full <= 1'b0;
            cnt       <= '0;
            tx        <= 1'b0;
            busy      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par       <= ^hold;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            cnt   <= '0;
            tx    <= 1'b1;
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (stop_end) begin
            done <= 1'b1;
            cnt  <= '0;
            if (hold_full) begin
              state     <= START;
              shreg     <= hold;
              hold_full <= 1'b0;
              tx        <= 1'b0;
`ifdef UART_TX_PARITY_EN
              par       <= ^hold;
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed frame checks on 1- and 2-stop-bit builds.
// Ticks are pulsed every other clk; tx is checked after every tick.
module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] dat = 8'h00;
  bit         sel = 1'b0;

  logic tx1, busy1, done1;
  logic tx2, busy2, done2;
  logic tx_s, busy_s, done_s, rdy_s;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int ticks = 0;
  int tdone = 0;

  uart_transmitter_if b1();
  uart_transmitter_if b2();

  assign b1.tx_valid = vld & ~sel;
  assign b1.tx_data  = dat;
  assign b2.tx_valid = vld & sel;
  assign b2.tx_data  = dat;

  assign tx_s   = sel ? tx2 : tx1;
  assign busy_s = sel ? busy2 : busy1;
  assign done_s = sel ? done2 : done1;
  assign rdy_s  = sel ? b2.tx_ready : b1.tx_ready;

  uart_transmitter #(.SAMPLES(16), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .tick(tick), .bus(b1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  uart_transmitter #(.SAMPLES(16), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .tick(tick), .bus(b2),
    .tx(tx2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic t);
    logic acc;
    tick = t;
    acc = vld & rdy_s & ~reset;
    @(posedge clk);
    #1;
    if (t) ticks++;
    if (acc) begin
      vld = 1'b0;
      accepts++;
    end
  endtask

  function automatic logic fbit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (P == 1 && k == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic put(input logic [7:0] d);
    int a0;
    a0 = accepts;
    vld = 1'b1;
    dat = d;
    for (int i = 0; i < 64 && accepts == a0; i++) step(1'b0);
    chk("accept", accepts - a0, 1);
    chk("rdy_full", rdy_s, 1'b0);
    step(1'b0);
    chk("start_tx", tx_s, 1'b0);
    chk("start_busy", busy_s, 1'b1);
    chk("start_rdy", rdy_s, 1'b1);
  endtask

  task automatic run_frame(input logic [7:0] d, input int stops,
                           input int arm_at, input logic [7:0] arm_d,
                           input int stall_at, input int abort_at);
    int f;
    int n;
    f = 9 + P + stops;
    n = 0;
    while (n < f * 16) begin
      if (n == abort_at) return;
      if (n == arm_at) begin
        vld = 1'b1;
        dat = arm_d;
      end
      if (n == stall_at) begin
        repeat (1000) step(1'b0);
        chk("stall_tx", tx_s, fbit(d, n / 16));
        chk("stall_busy", busy_s, 1'b1);
        chk("stall_done", done_s, 1'b0);
      end
      step(1'b0);
      step(1'b1);
      n++;
      if (n < f * 16) begin
        chk($sformatf("tx_%02h_t%0d", d, n), tx_s, fbit(d, n / 16));
        chk("busy_mid", busy_s, 1'b1);
        chk("done_mid", done_s, 1'b0);
      end else begin
        chk($sformatf("done_%02h", d), done_s, 1'b1);
        tdone = ticks;
      end
    end
  endtask

  task automatic end_idle();
    chk("end_busy", busy_s, 1'b0);
    chk("end_tx", tx_s, 1'b1);
    chk("end_rdy", rdy_s, 1'b1);
    step(1'b0);
    chk("done_pulse", done_s, 1'b0);
  endtask

  initial begin
    int t1;
    int a0;

    // reset dominates a valid byte and ticks
    reset = 1'b1;
    vld = 1'b1;
    dat = 8'hEE;
    step(1'b1);
    step(1'b1);
    reset = 1'b0;
    vld = 1'b0;
    chk("rst_tx", tx_s, 1'b1);
    chk("rst_busy", busy_s, 1'b0);
    chk("rst_done", done_s, 1'b0);
    chk("rst_rdy", rdy_s, 1'b1);
    chk("rst_noacc", accepts, 0);
    repeat (4) step(1'b1);
    chk("idle_tick_busy", busy_s, 1'b0);
    chk("idle_tick_tx", tx_s, 1'b1);

    // basic frames
    put(8'hA5);
    t1 = ticks;
    run_frame(8'hA5, 1, -1, 8'h00, -1, -1);
    chk("a5_len", tdone - t1, (10 + P) * 16);
    end_idle();

    put(8'h01);
    run_frame(8'h01, 1, -1, 8'h00, -1, -1);
    end_idle();

    // back-to-back: second byte offered during DATA of the first
    a0 = accepts;
    put(8'h00);
    run_frame(8'h00, 1, 20, 8'hFF, -1, -1);
    t1 = tdone;
    chk("b2b_acc", accepts - a0, 2);
    chk("b2b_tx", tx_s, 1'b0);
    chk("b2b_busy", busy_s, 1'b1);
    chk("b2b_rdy", rdy_s, 1'b1);
    run_frame(8'hFF, 1, -1, 8'h00, -1, -1);
    chk("b2b_gap", tdone - t1, (10 + P) * 16);
    end_idle();

    // reset mid data bit 3, with a byte waiting in the buffer
    put(8'h3C);
    run_frame(8'h3C, 1, 30, 8'h99, -1, 72);
    chk("pre_abort_tx", tx_s, 1'b1);
    chk("pre_abort_rdy", rdy_s, 1'b0);
    vld = 1'b1;
    dat = 8'h77;
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    vld = 1'b0;
    chk("abort_tx", tx_s, 1'b1);
    chk("abort_busy", busy_s, 1'b0);
    chk("abort_rdy", rdy_s, 1'b1);
    chk("abort_done", done_s, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1);
      chk("abort_idle", {done_s, busy_s, tx_s}, 3'b001);
    end
    put(8'h5A);
    run_frame(8'h5A, 1, -1, 8'h00, -1, -1);
    end_idle();

    // tick stall mid data
    put(8'hC3);
    run_frame(8'hC3, 1, -1, 8'h00, 83, -1);
    end_idle();

    // two stop bits
    sel = 1'b1;
    put(8'h55);
    t1 = ticks;
    run_frame(8'h55, 2, -1, 8'h00, -1, -1);
    chk("two_stop_len", tdone - t1, (11 + P) * 16);
    end_idle();
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
